// File: rtl/mem_load_store_unit_pkg.sv
// Shared definitions for the load/store unit.
//   lsu_state_e : FSM state encoding (IDLE, WAIT, WB)
//   REG_T7      : register index that every load writes back to
//   LAT_MIN/MAX : legal range of the load latency parameter
//   CNT_W       : width of the load latency down-counter
`timescale 1ns/1ps
package mem_load_store_unit_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      WB   = 2'd2
   } lsu_state_e;

   localparam logic [3:0] REG_T7  = 4'd7;
   localparam int         LAT_MIN = 1;
   localparam int         LAT_MAX = 15;
   localparam int         CNT_W   = 4;

   // Counter preload for a load: WAIT lasts LAT-1 cycles and exits on
   // terminal count 0, so the preload is LAT-2. Only used when LAT >= 2.
   function automatic logic [CNT_W-1:0] wait_count(input int unsigned lat);
      return CNT_W'(lat - 2);
   endfunction

endpackage

// File: rtl/mem_load_store_unit_dmem_array.sv
// W x 2^A data memory.
//   clk      : write clock
//   we       : write enable (write occurs at the rising edge)
//   waddr    : write address
//   wdata    : write data
//   raddr    : load read address
//   rdata    : combinational mem[raddr]
//   dbg_addr : debug read address
//   dbg_data : combinational mem[dbg_addr]
// Contents are intentionally not reset.
`timescale 1ns/1ps
module dmem_array #(
   parameter int W = 8,
   parameter int A = 8
) (
   input  logic         clk,
   input  logic         we,
   input  logic [A-1:0] waddr,
   input  logic [W-1:0] wdata,
   input  logic [A-1:0] raddr,
   output logic [W-1:0] rdata,
   input  logic [A-1:0] dbg_addr,
   output logic [W-1:0] dbg_data
);

   logic [W-1:0] mem_q [2**A];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata    = mem_q[raddr];
   assign dbg_data = mem_q[dbg_addr];

endmodule

// File: rtl/mem_load_store_unit.sv
// Load/store unit on the data-memory side of the register file.
//   clk, reset           : system clock, synchronous active-high reset
//   req_valid/req_ready  : request handshake from decode/execute
//   req_write            : 1 = store, 0 = load
//   req_addr, req_wdata  : word address and store data
//   wb_en/wb_addr/wb_data: register file write-from-memory (always $t7)
//   busy                 : load in flight
//   done                 : one-cycle pulse after a store is accepted
//   dbg_addr/dbg_data    : side-effect-free combinational memory peek
//
// state | meaning
// IDLE  | ready for a request; stores complete here in one cycle
// WAIT  | load accepted, counting down the remaining latency
// WB    | wb_en high with the loaded word; back to IDLE next edge
`timescale 1ns/1ps
module mem_load_store_unit
   import mem_load_store_unit_pkg::*;
#(
   parameter int W   = 8,
   parameter int A   = 8,
   parameter int D   = 4,
   parameter int LAT = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic         req_write,
   input  logic [A-1:0] req_addr,
   input  logic [W-1:0] req_wdata,
   output logic         wb_en,
   output logic [D-1:0] wb_addr,
   output logic [W-1:0] wb_data,
   output logic         busy,
   output logic         done,
   input  logic [A-1:0] dbg_addr,
   output logic [W-1:0] dbg_data
);

   if (LAT < LAT_MIN || LAT > LAT_MAX) begin : g_bad_lat
      $error("mem_load_store_unit: LAT out of range 1..15");
   end

   lsu_state_e       state_q,   state_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;
   logic [A-1:0]     addr_q,    addr_d;
   logic             wb_en_q,   wb_en_d;
   logic [W-1:0]     wb_data_q, wb_data_d;
   logic             done_q,    done_d;

   logic             accept;
   logic             mem_we;
   logic [A-1:0]     rd_addr;
   logic [W-1:0]     rd_data;

   // Ready is gated by reset so nothing (in particular no store) is
   // accepted on an edge where reset is high.
   assign req_ready = (state_q == IDLE) && !reset;
   assign accept    = req_valid && req_ready;
   assign mem_we    = accept && req_write;

   // With LAT=1 the load data is captured at the accept edge, so the read
   // port must see the request address directly; otherwise the latched one.
   assign rd_addr = (state_q == IDLE) ? req_addr : addr_q;

   dmem_array #(
      .W (W),
      .A (A)
   ) u_dmem (
      .clk      (clk),
      .we       (mem_we),
      .waddr    (req_addr),
      .wdata    (req_wdata),
      .raddr    (rd_addr),
      .rdata    (rd_data),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      wb_en_d   = 1'b0;
      wb_data_d = wb_data_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (req_write) begin
                  done_d = 1'b1;
               end else begin
                  addr_d = req_addr;
                  if (LAT == 1) begin
                     state_d   = WB;
                     wb_en_d   = 1'b1;
                     wb_data_d = rd_data;
                  end else begin
                     state_d = WAIT;
                     cnt_d   = wait_count(LAT);
                  end
               end
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d   = WB;
               wb_en_d   = 1'b1;
               wb_data_d = rd_data;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         WB: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         addr_q    <= '0;
         wb_en_q   <= 1'b0;
         wb_data_q <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         wb_en_q   <= wb_en_d;
         wb_data_q <= wb_data_d;
         done_q    <= done_d;
      end
   end

   assign wb_en   = wb_en_q;
   assign wb_data = wb_data_q;
   assign wb_addr = D'(REG_T7);
   assign done    = done_q;
   assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_mem_load_store_unit.sv
`timescale 1ns/1ps
module tb_mem_load_store_unit;

   logic       clk = 1'b0;
   logic       reset = 1'b1;

   // LAT=2 instance
   logic       req_valid = 1'b0, req_write = 1'b0;
   logic [7:0] req_addr = 8'h00, req_wdata = 8'h00, dbg_addr = 8'h00;
   logic       req_ready, wb_en, busy, done;
   logic [3:0] wb_addr;
   logic [7:0] wb_data, dbg_data;

   // LAT=1 instance
   logic       l1_valid = 1'b0, l1_write = 1'b0;
   logic [7:0] l1_addr = 8'h00, l1_wdata = 8'h00, l1_dbg_addr = 8'h00;
   logic       l1_ready, l1_wb_en, l1_busy, l1_done;
   logic [3:0] l1_wb_addr;
   logic [7:0] l1_wb_data, l1_dbg_data;

   int checks = 0;
   int errors = 0;
   int wb_cnt0 = 0;
   int wb_cnt1 = 0;
   int overlap = 0;

   always #5 clk = ~clk;

   mem_load_store_unit #(.W(8), .A(8), .D(4), .LAT(2)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .busy(busy), .done(done),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   mem_load_store_unit #(.W(8), .A(8), .D(4), .LAT(1)) dut_l1 (
      .clk(clk), .reset(reset),
      .req_valid(l1_valid), .req_ready(l1_ready), .req_write(l1_write),
      .req_addr(l1_addr), .req_wdata(l1_wdata),
      .wb_en(l1_wb_en), .wb_addr(l1_wb_addr), .wb_data(l1_wb_data),
      .busy(l1_busy), .done(l1_done),
      .dbg_addr(l1_dbg_addr), .dbg_data(l1_dbg_data)
   );

   always @(posedge clk) begin
      if (wb_en === 1'b1) wb_cnt0++;
      if (l1_wb_en === 1'b1) wb_cnt1++;
      if ((wb_en === 1'b1 && done === 1'b1) || (l1_wb_en === 1'b1 && l1_done === 1'b1)) overlap++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (2) step();
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b exp=0", req_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
      checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL rst_wb_en got=%b exp=0", wb_en); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", done); end
      checks++; if (wb_data !== 8'h00) begin errors++; $display("FAIL rst_wb_data got=%h exp=00", wb_data); end
      checks++; if (wb_addr !== 4'd7) begin errors++; $display("FAIL rst_wb_addr got=%0d exp=7", wb_addr); end
      checks++; if (l1_ready !== 1'b0) begin errors++; $display("FAIL rst_l1_ready got=%b exp=0", l1_ready); end
      reset = 1'b0;
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got=%b exp=1", req_ready); end
   endtask

   task automatic test_store_load();
      req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h10; req_wdata = 8'hA5;
      step();
      req_valid = 1'b0;
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL sl_done got=%b exp=1", done); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sl_store_busy got=%b exp=0", busy); end
      step();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL sl_done_pulse got=%b exp=0", done); end
      req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h10;
      step();
      req_valid = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sl_wait_busy got=%b exp=1", busy); end
      checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL sl_wait_wb_en got=%b exp=0", wb_en); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL sl_wait_ready got=%b exp=0", req_ready); end
      step();
      checks++; if (wb_en !== 1'b1) begin errors++; $display("FAIL sl_wb_en got=%b exp=1", wb_en); end
      checks++; if (wb_data !== 8'hA5) begin errors++; $display("FAIL sl_wb_data got=%h exp=a5", wb_data); end
      checks++; if (wb_addr !== 4'd7) begin errors++; $display("FAIL sl_wb_addr got=%0d exp=7", wb_addr); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sl_wb_busy got=%b exp=1", busy); end
      step();
      checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL sl_wb_pulse got=%b exp=0", wb_en); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sl_idle_busy got=%b exp=0", busy); end
   endtask

   task automatic test_hold_second_load();
      int n0;
      req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h11; req_wdata = 8'h3C;
      step();
      req_valid = 1'b0;
      n0 = wb_cnt0;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h10;
      step();
      req_addr = 8'h11;
      #1;
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL hold_ready_wait got=%b exp=0", req_ready); end
      step();
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL hold_ready_wb got=%b exp=0", req_ready); end
      checks++; if (wb_data !== 8'hA5 || wb_en !== 1'b1) begin errors++; $display("FAIL hold_first_wb got=%b/%h exp=1/a5", wb_en, wb_data); end
      step();
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL hold_ready_idle got=%b exp=1", req_ready); end
      step();
      req_valid = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hold_second_busy got=%b exp=1", busy); end
      step();
      checks++; if (wb_data !== 8'h3C || wb_en !== 1'b1) begin errors++; $display("FAIL hold_second_wb got=%b/%h exp=1/3c", wb_en, wb_data); end
      repeat (3) step();
      checks++; if (wb_cnt0 - n0 !== 2) begin errors++; $display("FAIL hold_pulse_count got=%0d exp=2", wb_cnt0 - n0); end
   endtask

   task automatic test_store_then_load();
      req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h20; req_wdata = 8'h5A;
      step();
      req_write = 1'b0;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL stl_ready got=%b exp=1", req_ready); end
      step();
      req_valid = 1'b0;
      step();
      checks++; if (wb_en !== 1'b1 || wb_data !== 8'h5A) begin errors++; $display("FAIL stl_wb got=%b/%h exp=1/5a", wb_en, wb_data); end
      step();
   endtask

   task automatic test_reset_in_wait();
      int n0;
      req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h30; req_wdata = 8'h11;
      step();
      req_write = 1'b0; req_addr = 8'h10;
      step();
      req_valid = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rw_busy_wait got=%b exp=1", busy); end
      n0 = wb_cnt0;
      reset = 1'b1;
      step();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rw_busy_after got=%b exp=0", busy); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rw_ready_in_reset got=%b exp=0", req_ready); end
      reset = 1'b0;
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rw_ready_after got=%b exp=1", req_ready); end
      repeat (4) step();
      checks++; if (wb_cnt0 !== n0) begin errors++; $display("FAIL rw_no_wb got=%0d exp=%0d", wb_cnt0, n0); end
      // A store presented while reset is high must not land.
      reset = 1'b1;
      req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h30; req_wdata = 8'h77;
      step();
      req_valid = 1'b0;
      reset = 1'b0;
      dbg_addr = 8'h30;
      #1;
      checks++; if (dbg_data !== 8'h11) begin errors++; $display("FAIL rw_store_blocked got=%h exp=11", dbg_data); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rw_done_blocked got=%b exp=0", done); end
   endtask

   task automatic test_boundary();
      req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h00; req_wdata = 8'h01;
      step();
      req_addr = 8'hFF; req_wdata = 8'hFE;
      step();
      req_write = 1'b0; req_addr = 8'h00;
      step();
      req_valid = 1'b0;
      step();
      checks++; if (wb_en !== 1'b1 || wb_data !== 8'h01) begin errors++; $display("FAIL bnd_load0 got=%b/%h exp=1/01", wb_en, wb_data); end
      step();
      req_valid = 1'b1; req_addr = 8'hFF;
      step();
      req_valid = 1'b0;
      step();
      checks++; if (wb_en !== 1'b1 || wb_data !== 8'hFE) begin errors++; $display("FAIL bnd_loadff got=%b/%h exp=1/fe", wb_en, wb_data); end
      step();
      dbg_addr = 8'hFF;
      #1;
      checks++; if (dbg_data !== 8'hFE) begin errors++; $display("FAIL bnd_dbg_ff got=%h exp=fe", dbg_data); end
      dbg_addr = 8'h00;
      #1;
      checks++; if (dbg_data !== 8'h01) begin errors++; $display("FAIL bnd_dbg_00 got=%h exp=01", dbg_data); end
   endtask

   task automatic test_lat1();
      logic [7:0] exp_data [4];
      exp_data[0] = 8'h11; exp_data[1] = 8'h22; exp_data[2] = 8'h33; exp_data[3] = 8'h44;
      l1_valid = 1'b1; l1_write = 1'b1;
      for (int i = 0; i < 4; i++) begin
         l1_addr = 8'h40 + 8'(i); l1_wdata = exp_data[i];
         step();
         checks++; if (l1_done !== 1'b1 || l1_ready !== 1'b1) begin errors++; $display("FAIL l1_store%0d done/ready got=%b/%b exp=1/1", i, l1_done, l1_ready); end
      end
      l1_valid = 1'b0;
      step();
      checks++; if (l1_done !== 1'b0) begin errors++; $display("FAIL l1_done_end got=%b exp=0", l1_done); end
      for (int i = 0; i < 4; i++) begin
         l1_dbg_addr = 8'h40 + 8'(i);
         #1;
         checks++; if (l1_dbg_data !== exp_data[i]) begin errors++; $display("FAIL l1_mem%0d got=%h exp=%h", i, l1_dbg_data, exp_data[i]); end
      end
      l1_valid = 1'b1; l1_write = 1'b0; l1_addr = 8'h42;
      step();
      l1_valid = 1'b0;
      checks++; if (l1_wb_en !== 1'b1 || l1_wb_data !== 8'h33) begin errors++; $display("FAIL l1_wb got=%b/%h exp=1/33", l1_wb_en, l1_wb_data); end
      checks++; if (l1_wb_addr !== 4'd7 || l1_busy !== 1'b1) begin errors++; $display("FAIL l1_wb_addr_busy got=%0d/%b exp=7/1", l1_wb_addr, l1_busy); end
      step();
      checks++; if (l1_wb_en !== 1'b0 || l1_busy !== 1'b0) begin errors++; $display("FAIL l1_after got=%b/%b exp=0/0", l1_wb_en, l1_busy); end
      step();
      checks++; if (wb_cnt1 !== 1) begin errors++; $display("FAIL l1_pulse_count got=%0d exp=1", wb_cnt1); end
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_hold_second_load();
      test_store_then_load();
      test_reset_in_wait();
      test_boundary();
      test_lat1();
      checks++; if (overlap !== 0) begin errors++; $display("FAIL done_wb_overlap got=%0d exp=0", overlap); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
